lsu_mem_stage: RTL and testbench

//  Load/store stage directly downstream of the ALU: takes the ALU result as effective address, performs one

---
 rtl/lsu_mem_stage_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/lsu_mem_stage.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store memory stage: access sizes, FSM states
// and byte-lane masks.
package lsu_mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated data,
// alignment check, and load-data extraction with sign/zero extension.
module lsu_lane_align
  import lsu_mem_stage_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = '0;
    lane_wdata = '0;
    misalign   = 1'b0;
    load_data  = '0;
    case (size)
      SIZE_B: begin
        be         = BE_BYTE0 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        lane_wdata = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
        load_data  = {{16{~load_unsigned & half[15]}}, half};
      end
      SIZE_W: begin
        be         = BE_WORD;
        lane_wdata = wdata;
        misalign   = |addr_lo;
        load_data  = rdata;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: accepts one access, runs it on a variable-latency memory
// bus with a timeout, and returns aligned load data or an error for one cycle.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e      state, state_next;
  logic        lat_we, lat_uns;
  size_e       lat_size;
  logic [31:0] lat_addr, lat_wdata;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, timeout_hit;

  size_e       al_size;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_lane_wdata, al_load;
  logic        al_misalign;

  // In IDLE the aligner looks at the live request so the error path is decided
  // at accept; afterwards it looks at the latched request.
  assign al_size    = (state == ST_IDLE) ? size_e'(req_size) : lat_size;
  assign al_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : lat_addr[1:0];

  lsu_lane_align u_align (
    .size          (al_size),
    .addr_lo       (al_addr_lo),
    .load_unsigned (lat_uns),
    .wdata         (lat_wdata),
    .rdata         (mem_rdata),
    .be            (al_be),
    .lane_wdata    (al_lane_wdata),
    .misalign      (al_misalign),
    .load_data     (al_load)
  );

  assign accept      = (state == ST_IDLE) & req_valid;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = al_misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (mem_ack || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latches, timeout counter and registered response; an ack on the timeout
  // cycle is checked first so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= SIZE_B;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_uns   <= req_unsigned;
      lat_size  <= size_e'(req_size);
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= al_misalign;
    end else if (state == ST_BUS) begin
      cnt <= cnt + 1'b1;
      if (mem_ack) begin
        err_q   <= 1'b0;
        rdata_q <= lat_we ? '0 : al_load;
      end else if (timeout_hit) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end else if (state == ST_RESP) begin
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    stall      = (state == ST_BUS) | ((state == ST_IDLE) & req_valid);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (state == ST_BUS) begin
      mem_req   = 1'b1;
      mem_we    = lat_we;
      mem_addr  = {lat_addr[31:2], 2'b00};
      mem_be    = al_be;
      mem_wdata = al_lane_wdata;
    end
    if (state == ST_RESP) begin
      resp_valid = 1'b1;
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, randomized accesses against a
// byte-arithmetic reference model, and reset/ignored-ack sequences.
module tb_lsu_mem_stage;

  localparam int T = 16;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_stage #(.TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] wd_lane;
    logic [31:0] rd_out;
    logic        err;
  } vec_t;

  // Reference model: byte offsets, masks and multiplication, no lane muxes.
  function automatic void ref_model(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] rd, input int delay,
                                    output logic bus, output logic [3:0] be,
                                    output logic [31:0] wdo, output logic [31:0] rdo,
                                    output logic err);
    int off, nbytes;
    logic [63:0] mask, v;
    off = int'(addr % 4);
    bus = 1'b0; be = '0; wdo = '0; rdo = '0; err = 1'b1;
    if (size == 2'd3 || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0)) return;
    bus = 1'b1;
    nbytes = 1 << size;
    case (size)
      2'd0: begin be = 4'(1 << off); wdo = {24'h0, wd[7:0]} * 32'h0101_0101; end
      2'd1: begin be = (off >= 2) ? 4'hC : 4'h3; wdo = {16'h0, wd[15:0]} * 32'h0001_0001; end
      default: begin be = 4'hF; wdo = wd; end
    endcase
    err = (delay >= T);
    if (!we && !err) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = ({32'h0, rd} >> (8 * off)) & mask;
      if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
      rdo = v[31:0];
    end
  endfunction

  // Driver + checker for one access; delay >= T means the bus never acks.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay, input logic bus,
                            input logic [3:0] be, input logic [31:0] wdo,
                            input logic [31:0] rdo, input logic err);
    int n_bus;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    check({tag, ".req_ready"}, req_ready, 1);
    check({tag, ".stall_req"}, stall, 1);
    @(posedge clk);
    if (bus) begin
      n_bus = (delay >= T) ? T : delay + 1;
      for (int i = 0; i < n_bus; i++) begin
        @(negedge clk);
        mem_ack = 1'b0;
        req_addr = $urandom;
        req_size = 2'($urandom_range(0, 3));
        req_wdata = $urandom;
        #1;
        check($sformatf("%s.mem_req[%0d]", tag, i), mem_req, 1);
        check($sformatf("%s.mem_we[%0d]", tag, i), mem_we, we);
        check($sformatf("%s.mem_addr[%0d]", tag, i), mem_addr, addr & ~32'h3);
        check($sformatf("%s.mem_be[%0d]", tag, i), mem_be, be);
        if (we) check($sformatf("%s.mem_wdata[%0d]", tag, i), mem_wdata, wdo);
        check($sformatf("%s.req_ready_busy[%0d]", tag, i), req_ready, 0);
        check($sformatf("%s.stall_bus[%0d]", tag, i), stall, 1);
        check($sformatf("%s.resp_valid_early[%0d]", tag, i), resp_valid, 0);
        if (i == delay) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    req_valid = 1'b0;
    #1;
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".resp_err"}, resp_err, err);
    check({tag, ".resp_rdata"}, resp_rdata, rdo);
    check({tag, ".stall_resp"}, stall, 0);
    check({tag, ".mem_req_resp"}, mem_req, 0);
    @(negedge clk);
    #1;
    check({tag, ".resp_valid_pulse"}, resp_valid, 0);
    check({tag, ".req_ready_after"}, req_ready, 1);
  endtask

  vec_t vecs[12];

  initial begin
    logic bus_e, err_e;
    logic [3:0] be_e;
    logic [31:0] wd_e, rd_e, a, wd, rd;
    logic [1:0] sz;
    logic we, uns;
    int dly;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.req_ready", req_ready, 1);
    check("rst.mem_req", mem_req, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset.req_ready", req_ready, 1);
    check("reset.resp_valid", resp_valid, 0);
    check("reset.stall", stall, 0);
    check("reset.mem_be", mem_be, 0);
    check("reset.resp_rdata", resp_rdata, 0);

    // directed table: expected values worked out by hand
    vecs[0]  = '{1, 2'd2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0};
    vecs[1]  = '{0, 2'd0, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 3, 1, 4'h8, 32'h0, 32'hFFFF_FF80, 0};
    vecs[2]  = '{0, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h8011_2233, 3, 1, 4'h8, 32'h0, 32'h0000_0080, 0};
    vecs[3]  = '{1, 2'd1, 0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 1, 4'hC, 32'hABCD_ABCD, 32'h0, 0};
    vecs[4]  = '{0, 2'd1, 0, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1};
    vecs[5]  = '{0, 2'd3, 0, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1};
    vecs[6]  = '{0, 2'd2, 0, 32'h0000_0102, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1};
    vecs[7]  = '{0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1, 1, 4'hF, 32'h0, 32'h1234_5678, 0};
    vecs[8]  = '{0, 2'd1, 0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2, 1, 4'hC, 32'h0, 32'hFFFF_8001, 0};
    vecs[9]  = '{1, 2'd0, 0, 32'h0000_0101, 32'h0123_45A7, 32'h0, 0, 1, 4'h2, 32'hA7A7_A7A7, 32'h0, 0};
    vecs[10] = '{0, 2'd2, 0, 32'h0000_0200, 32'h0, 32'h5555_5555, 99, 1, 4'hF, 32'h0, 32'h0, 1};
    vecs[11] = '{0, 2'd2, 0, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, T - 1, 1, 4'hF, 32'h0, 32'hCAFE_F00D, 0};

    for (int k = 0; k < 12; k++) begin
      run_access($sformatf("vec%0d", k), vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr,
                 vecs[k].wdata, vecs[k].rdata, vecs[k].delay, vecs[k].bus, vecs[k].be,
                 vecs[k].wd_lane, vecs[k].rd_out, vecs[k].err);
    end

    // ack while idle must be ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle_ack.resp_valid", resp_valid, 0);
    check("idle_ack.req_ready", req_ready, 1);
    check("idle_ack.mem_req", mem_req, 0);

    // reset two cycles into the bus phase, ack arrives right after
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0300;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rst_mid.mem_req0", mem_req, 1);
    @(negedge clk);
    #1;
    check("rst_mid.mem_req1", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("rst_mid.req_ready", req_ready, 1);
    check("rst_mid.mem_req", mem_req, 0);
    check("rst_mid.resp_valid", resp_valid, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("rst_mid.resp_valid_late", resp_valid, 0);
    check("rst_mid.req_ready_late", req_ready, 1);
    check("rst_mid.mem_req_late", mem_req, 0);

    // randomized accesses against the reference model
    for (int k = 0; k < 60; k++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd  = $urandom;
      rd  = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? T + 3 : $urandom_range(0, 4);
      ref_model(we, sz, uns, a, wd, rd, dly, bus_e, be_e, wd_e, rd_e, err_e);
      run_access($sformatf("rnd%0d", k), we, sz, uns, a, wd, rd, dly, bus_e, be_e, wd_e, rd_e, err_e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
